// File: rtl/tri_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus, with a one-cycle
// all-released turnaround between owners and a cap on each ownership period.
module tri_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         oe,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] ptr_reg, ptr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [N-1:0]  grant_reg, grant_next;
  logic [N-1:0]  oe_reg, oe_next;
  logic [PW-1:0] owner_reg, owner_next;
  logic          busy_reg, busy_next;

  logic [N-1:0]  rot_req;
  logic [PW-1:0] win_off;
  logic [PW:0]   win_sum;
  logic [PW-1:0] winner;
  logic [N-1:0]  win_onehot;
  logic [PW-1:0] ptr_after;
  logic          rel;

  // rot_req[i] is the request of requester (ptr + i) mod N, so bit 0 has top priority
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      assign sum = {1'b0, ptr_reg} + (PW+1)'(gi);
      assign idx = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
      assign rot_req[gi] = req[idx];
    end
  endgenerate

  always_comb begin
    win_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_req[i]) win_off = PW'(i);
    end
  end

  assign win_sum    = {1'b0, ptr_reg} + {1'b0, win_off};
  assign winner     = (win_sum >= (PW+1)'(N)) ? PW'(win_sum - (PW+1)'(N)) : PW'(win_sum);
  assign win_onehot = N'(1) << winner;
  assign ptr_after  = (winner == PW'(N - 1)) ? '0 : winner + PW'(1);

  assign rel = !req[owner_reg] || (cnt_reg == CW'(MAX_HOLD));

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    oe_next    = oe_reg;
    owner_next = owner_reg;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          grant_next = win_onehot;
          owner_next = winner;
          ptr_next   = ptr_after;
          state_next = TURN;
        end
      end

      // Owner is committed even if its request drops here; release comes from OWN.
      TURN: begin
        oe_next    = grant_reg;
        cnt_next   = CW'(1);
        state_next = OWN;
      end

      OWN: begin
        if (!rel) begin
          cnt_next = cnt_reg + CW'(1);
        end else begin
          oe_next  = '0;
          cnt_next = '0;
          if (|req) begin
            grant_next = win_onehot;
            owner_next = winner;
            ptr_next   = ptr_after;
            state_next = TURN;
          end else begin
            grant_next = '0;
            owner_next = '0;
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
        oe_next    = '0;
        owner_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy_next = (state_next != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      grant_reg <= '0;
      oe_reg    <= '0;
      owner_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      oe_reg    <= oe_next;
      owner_reg <= owner_next;
      busy_reg  <= busy_next;
    end
  end

  assign grant = grant_reg;
  assign oe    = oe_reg;
  assign owner = owner_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: three instances (MAX_HOLD 8, 2, 3) driven from a
// cycle-by-cycle vector table, a few hand-timed sequences and an overlap monitor.
module tb_tri_bus_arbiter;

  localparam int N = 4;

  typedef struct {
    int         sel;
    bit         rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] oe;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n_a [3];
  logic [3:0] req_a   [3];
  logic [3:0] grant_a [3];
  logic [3:0] oe_a    [3];
  logic [1:0] owner_a [3];
  logic       busy_a  [3];

  int checks   = 0;
  int failures = 0;

  vec_t       vecs [$];
  vec_t       sb   [$];
  logic [3:0] prev_oe [3];
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      tri_bus_arbiter #(
        .N(N),
        .MAX_HOLD(gi == 0 ? 8 : (gi == 1 ? 2 : 3))
      ) u_dut (
        .clk  (clk),
        .rst_n(rst_n_a[gi]),
        .req  (req_a[gi]),
        .grant(grant_a[gi]),
        .oe   (oe_a[gi]),
        .owner(owner_a[gi]),
        .busy (busy_a[gi])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input int s, input bit r, input logic [3:0] rq, input logic [3:0] g,
                     input logic [3:0] o_e, input logic [1:0] ow, input logic b);
    vecs.push_back('{s, r, rq, g, o_e, ow, b});
  endtask

  // Bus-safety invariants on every instance, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("onehot0_oe_dut%0d", i), 32'($onehot0(oe_a[i])), 32'd1);
        chk($sformatf("oe_in_grant_dut%0d", i), 32'(oe_a[i] & ~grant_a[i]), 32'd0);
        chk($sformatf("no_overlap_dut%0d", i),
            32'((prev_oe[i] != 4'b0) && (oe_a[i] != 4'b0) && (oe_a[i] != prev_oe[i])), 32'd0);
        prev_oe[i] = oe_a[i];
      end
    end
  end

  initial begin
    @(posedge clk);
    #1 mon_en = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         order [3];
    int         w;
    int         lat;
    int         hi;
    int         waitc;
    logic [3:0] oh;
    vec_t       e;

    for (int i = 0; i < 3; i++) begin
      rst_n_a[i] = 1'b0;
      req_a[i]   = 4'b0;
      prev_oe[i] = 4'b0;
    end

    // dut0: reset with everything requesting, then first winner must be 0
    add(0, 0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 1, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b1);
    add(0, 1, 4'b0000, 4'b0001, 4'b0001, 2'd0, 1'b1);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // dut0: single request for 5 cycles then drop
    add(0, 1, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b1);
    for (int k = 0; k < 4; k++) add(0, 1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // dut0: reset on the 2nd OWN cycle; afterwards ptr=0 picks 1 out of 1010, not 3
    add(0, 1, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b1);
    add(0, 1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1);
    add(0, 1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1);
    add(0, 0, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 1, 4'b1010, 4'b0010, 4'b0000, 2'd1, 1'b1);
    add(0, 1, 4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // dut1 (MAX_HOLD=2): round robin over 1011 -> 0,1,3,0,1,3
    order[0] = 0; order[1] = 1; order[2] = 3;
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      w  = order[r % 3];
      oh = 4'b0001 << w;
      add(1, 1, 4'b1011, oh, 4'b0000, 2'(w), 1'b1);
      add(1, 1, 4'b1011, oh, oh, 2'(w), 1'b1);
      add(1, 1, 4'b1011, oh, oh, 2'(w), 1'b1);
    end
    add(1, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // dut2 (MAX_HOLD=3): lone requester capped at 3 OWN cycles, re-granted via TURN
    add(2, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      add(2, 1, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1);
      for (int k = 0; k < 3; k++) add(2, 1, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1);
    end
    add(2, 1, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1);
    // request drops during TURN: OWN is still entered for one cycle
    add(2, 1, 4'b0000, 4'b0001, 4'b0001, 2'd0, 1'b1);
    add(2, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

    for (int v = 0; v < vecs.size(); v++) begin
      @(negedge clk);
      rst_n_a[vecs[v].sel] = vecs[v].rst_n;
      req_a[vecs[v].sel]   = vecs[v].req;
      sb.push_back(vecs[v]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      $display("vec %0d dut%0d rst_n=%b req=%b grant=%b oe=%b owner=%0d busy=%b",
               v, e.sel, e.rst_n, e.req, grant_a[e.sel], oe_a[e.sel], owner_a[e.sel], busy_a[e.sel]);
      chk($sformatf("vec%0d_grant", v), 32'(grant_a[e.sel]), 32'(e.grant));
      chk($sformatf("vec%0d_oe", v),    32'(oe_a[e.sel]),    32'(e.oe));
      chk($sformatf("vec%0d_owner", v), 32'(owner_a[e.sel]), 32'(e.owner));
      chk($sformatf("vec%0d_busy", v),  32'(busy_a[e.sel]),  32'(e.busy));
    end

    // dut0 (MAX_HOLD=8): idle latency to oe and full-length hold with req held
    @(negedge clk);
    req_a[0] = 4'b1000;
    lat = 0;
    while (oe_a[0] != 4'b1000 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("seq latency dut0 edges=%0d", lat);
    chk("idle_to_oe_edges", 32'(lat), 32'd2);
    hi = 0;
    while (oe_a[0] == 4'b1000 && hi < 20) begin
      hi++;
      @(posedge clk);
      #1;
    end
    $display("seq hold dut0 oe_cycles=%0d", hi);
    chk("max_hold_cycles", 32'(hi), 32'd8);
    chk("regrant_turn_busy", 32'(busy_a[0]), 32'd1);
    chk("regrant_turn_grant", 32'(grant_a[0]), 32'h8);
    @(negedge clk);
    req_a[0] = 4'b0000;
    waitc = 0;
    while (busy_a[0] && waitc < 10) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    $display("seq drain dut0 edges=%0d", waitc);
    chk("drain_to_idle_busy", 32'(busy_a[0]), 32'd0);
    chk("drain_to_idle_edges", 32'(waitc), 32'd2);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
# tri_bus_arbiter

Round-robin arbiter that shares one tri-state data bus among N requesters. It sits beside the per-requester tri-state buffers: it decides which requester owns the bus and drives each buffer's enable. It guarantees a one-cycle all-released turnaround between owners, so two drivers never overlap, and it caps each ownership period. All outputs are registered.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `MAX_HOLD`, default 8: maximum consecutive OWN cycles per grant, 1..255.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: synchronous active-low reset.
- `req`  in  N: request per requester. Level-sensitive; hold high while the bus is wanted.
- `grant`  out  N: one-hot owner select. Zero when no owner.
- `oe`  out  N: one-hot enable to the requesters' tri-state buffers. High only in OWN.
- `owner`  out  clog2(N): index of the granted requester. 0 when `grant` is 0.
- `busy`  out  1: high whenever state is not IDLE.

## Operation
- Three states: IDLE, TURN, OWN. Internal state: round-robin pointer `ptr` (clog2 N bits) and hold counter `cnt` (clog2(MAX_HOLD+1) bits).
- Winner selection: the first set bit of `req`, searching upward from `ptr` and wrapping modulo N. On each grant, `ptr <= winner+1` mod N.
- IDLE: `grant`, `oe` and `owner` are 0, `busy` is 0. If `req` is nonzero, select the winner, load `grant`/`owner`, go to TURN. `oe` stays 0.
- TURN: lasts exactly 1 cycle, with all `oe` low. Then go to OWN, set `oe` = `grant`, and set `cnt` = 1.
  - If `req[owner]` has dropped during TURN, still enter OWN. Release happens on the first OWN cycle.
- OWN: `oe[owner]` is high. Each cycle:
  - Release condition: `req[owner]` = 0, or `cnt` = MAX_HOLD.
  - If not releasing: `cnt` increments.
  - If releasing: `oe` clears on the same edge. If any `req` bit is set, choose a new winner, load `grant`, and go to TURN. Otherwise clear `grant`/`owner` and go to IDLE.
  - The releasing owner takes part in re-arbitration. Because `ptr` has moved past it, it wins again only if no other requester is asserting.
- Invariants, every cycle:
  - `oe` is one-hot or zero.
  - `oe` is a subset of `grant`.
  - Between two different nonzero `oe` values there is at least one cycle of `oe` = 0.
- `req` changes from non-owners never disturb the current OWN period.

## Timing
- Reset, with `rst_n` low at an edge:
  - State is IDLE; `grant`, `oe`, `owner`, `busy`, `cnt` are 0; `ptr` is 0.
  - This takes priority over all other activity, including mid-OWN. `oe` drops at that edge.
- Latency from an idle bus: `req` seen at edge k → `grant` and `busy` high after edge k, `oe` high after edge k+1.
- Handover: release condition seen at edge j → `oe` is 0 after edge j (TURN), new `oe` is high after edge j+1.
- Maximum OWN duration is MAX_HOLD cycles. `oe` is high for exactly MAX_HOLD cycles when `req` is held.
- Simultaneous requests: resolved purely by `ptr` order. No requester waits more than N-1 grants.
- With MAX_HOLD = 1, every grant gives one OWN cycle followed by one TURN cycle.

## Test plan
- **Reset values:** hold `rst_n`=0 for 2 cycles with `req`=4'b1111 → `grant`=0, `oe`=0, `owner`=0, `busy`=0. After release the first winner is requester 0.
- **Single request, N=4, MAX_HOLD=8:** `req`=4'b0100 for 5 cycles then 0 → `grant`=4'b0100 at k+1. `oe`=4'b0100 from k+2 for 4 cycles, until the cycle after `req` drops. Then IDLE with `busy`=0.
- **Round robin:** `req`=4'b1011 held, MAX_HOLD=2 → grant order 0,1,3,0,1,3. Each owner's `oe` is high for 2 cycles, with a 1-cycle `oe`=0 gap between owners.
- **Hold cap:** `req`=4'b0001 held alone, MAX_HOLD=3 → `oe` pattern 1,1,1,0,1,1,1,0,… Requester 0 is re-granted each time via TURN.
- **Mid-OWN reset:** `rst_n`=0 on the 2nd OWN cycle of requester 2 → `oe`=0 at that edge. Re-arbitration after reset starts at `ptr`=0.
- **Overlap checker, all scenarios:** assert `oe` is one-hot-or-zero, `oe` is a subset of `grant`, and no cycle moves directly from one nonzero `oe` to a different nonzero `oe`.
